// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared constants, call state and car cost function for the hall-call dispatcher (TIMEOUT/AGE_W used with CALL_AGE_EN)
package elevator_pkg;

  localparam int NFLOORS     = 5;
  localparam int FLOOR_W     = 3;
  localparam int COST_W      = FLOOR_W + 2;
  localparam int DIR_PENALTY = 4;
  localparam int TIMEOUT     = 64;
  localparam int AGE_W       = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    ASG_F = 2'd2,
    ASG_S = 2'd3
  } call_state_t;

  // Distance to the target plus a penalty when the car is heading away from it.
  // Both direction bits set is illegal and is costed like a stopped car.
  function automatic logic [COST_W-1:0] call_cost(
    input logic [FLOOR_W-1:0] car_floor,
    input logic               up,
    input logic               down,
    input logic [FLOOR_W-1:0] target
  );
    logic [COST_W-1:0] c;
    if (car_floor >= target) c = COST_W'(car_floor - target);
    else                     c = COST_W'(target - car_floor);
    if ((up && !down && target < car_floor) || (down && !up && target > car_floor))
      c = c + COST_W'(DIR_PENALTY);
    return c;
  endfunction

endpackage

// File: rtl/call_cost_compare.sv
// rtl/call_cost_compare.sv - picks the cheaper available car for one call, ties go to car f
module call_cost_compare
  import elevator_pkg::*;
(
  input  logic [COST_W-1:0] fcost,
  input  logic [COST_W-1:0] scost,
  input  logic              favail,
  input  logic              savail,
  output logic              win_s,
  output logic              valid
);

  // An unavailable car behaves as infinite cost; no winner when neither car is available.
  always_comb begin
    valid = favail | savail;
    win_s = savail && (!favail || (scost < fcost));
  end

endmodule

// File: rtl/hall_call_dispatcher.sv
// rtl/hall_call_dispatcher.sv - latches hall calls and assigns them to car f or car s (optional call aging: CALL_AGE_EN)
module hall_call_dispatcher
  import elevator_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NFLOORS-1:0] buttons,
  input  logic [FLOOR_W-1:0] ffloor,
  input  logic               fup,
  input  logic               fdown,
  input  logic [FLOOR_W-1:0] sfloor,
  input  logic               sup,
  input  logic               sdown,
  output logic [NFLOORS-1:0] fassign,
  output logic [NFLOORS-1:0] sassign,
  output logic [NFLOORS-1:0] pending
);

  call_state_t        st     [NFLOORS];
  call_state_t        st_nxt [NFLOORS];
  logic [NFLOORS-1:0] stopped;
  logic               sel_found;
  logic [FLOOR_W-1:0] sel;
  logic [COST_W-1:0]  fcost;
  logic [COST_W-1:0]  scost;
  logic               favail;
  logic               savail;
  logic               win_s;
  logic               win_valid;

`ifdef CALL_AGE_EN
  logic [AGE_W-1:0]   age [NFLOORS];
  logic [NFLOORS-1:0] excl_f;
  logic [NFLOORS-1:0] excl_s;
  logic [NFLOORS-1:0] timeout_hit;

  // An assigned call that has waited TIMEOUT cycles goes back to arbitration.
  always_comb begin
    for (int j = 0; j < NFLOORS; j++)
      timeout_hit[j] = (st[j] == ASG_F || st[j] == ASG_S) && (age[j] == AGE_W'(TIMEOUT));
  end
`endif

  // A car serves floor j only when parked there with no direction asserted.
  always_comb begin
    for (int j = 0; j < NFLOORS; j++)
      stopped[j] = (ffloor == FLOOR_W'(j) && !fup && !fdown) ||
                   (sfloor == FLOOR_W'(j) && !sup && !sdown);
  end

  // The lowest-index pending floor is the only one arbitrated this cycle.
  always_comb begin
    sel_found = 1'b0;
    sel       = '0;
    for (int i = 0; i < NFLOORS; i++) begin
      if (!sel_found && st[i] == PEND) begin
        sel_found = 1'b1;
        sel       = FLOOR_W'(i);
      end
    end
  end

  // Per-car cost and availability for the selected floor.
  always_comb begin
    fcost  = call_cost(ffloor, fup, fdown, sel);
    scost  = call_cost(sfloor, sup, sdown, sel);
`ifdef CALL_AGE_EN
    favail = (ffloor < FLOOR_W'(NFLOORS)) && !excl_f[sel];
    savail = (sfloor < FLOOR_W'(NFLOORS)) && !excl_s[sel];
`else
    favail = (ffloor < FLOOR_W'(NFLOORS));
    savail = (sfloor < FLOOR_W'(NFLOORS));
`endif
  end

  call_cost_compare u_cmp (
    .fcost  (fcost),
    .scost  (scost),
    .favail (favail),
    .savail (savail),
    .win_s  (win_s),
    .valid  (win_valid)
  );

  // Per-floor call state transitions; a stopped car clears before latch or assignment.
  always_comb begin
    for (int j = 0; j < NFLOORS; j++) begin
      st_nxt[j] = st[j];
      case (st[j])
        IDLE: if (!stopped[j] && buttons[j]) st_nxt[j] = PEND;
        PEND: begin
          if (stopped[j])
            st_nxt[j] = IDLE;
          else if (sel_found && sel == FLOOR_W'(j) && win_valid)
            st_nxt[j] = win_s ? ASG_S : ASG_F;
        end
        default: begin
          if (stopped[j])
            st_nxt[j] = IDLE;
`ifdef CALL_AGE_EN
          else if (timeout_hit[j])
            st_nxt[j] = PEND;
`endif
        end
      endcase
    end
  end

  // Register call state and the output decodes of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NFLOORS; j++) st[j] <= IDLE;
      fassign <= '0;
      sassign <= '0;
      pending <= '0;
    end else begin
      for (int j = 0; j < NFLOORS; j++) begin
        st[j]      <= st_nxt[j];
        fassign[j] <= (st_nxt[j] == ASG_F);
        sassign[j] <= (st_nxt[j] == ASG_S);
        pending[j] <= (st_nxt[j] == PEND);
      end
    end
  end

`ifdef CALL_AGE_EN
  // Age assigned calls and remember which car timed out so the retry avoids it once.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NFLOORS; j++) age[j] <= '0;
      excl_f <= '0;
      excl_s <= '0;
    end else begin
      for (int j = 0; j < NFLOORS; j++) begin
        if ((st[j] == ASG_F || st[j] == ASG_S) && (st_nxt[j] == ASG_F || st_nxt[j] == ASG_S))
          age[j] <= age[j] + AGE_W'(1);
        else
          age[j] <= '0;
        if (timeout_hit[j]) begin
          excl_f[j] <= (st[j] == ASG_F);
          excl_s[j] <= (st[j] == ASG_S);
        end else if (st_nxt[j] == IDLE || (st[j] == PEND && sel_found && sel == FLOOR_W'(j))) begin
          excl_f[j] <= 1'b0;
          excl_s[j] <= 1'b0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// tb/tb_hall_call_dispatcher.sv - randomized bench for hall_call_dispatcher against a call-list reference model
module tb_hall_call_dispatcher;
  import elevator_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic [NFLOORS-1:0] buttons;
  logic [FLOOR_W-1:0] ffloor, sfloor;
  logic               fup, fdown, sup, sdown;
  logic [NFLOORS-1:0] fassign, sassign, pending;

  int vectors     = 0;
  int miscompares = 0;

  // Reference: owner of each floor's call: 0 none, 1 waiting, 2 car f, 3 car s.
  int call_owner [NFLOORS];

  always #5 clk = ~clk;

  hall_call_dispatcher dut (
    .clk     (clk),
    .reset   (reset),
    .buttons (buttons),
    .ffloor  (ffloor),
    .fup     (fup),
    .fdown   (fdown),
    .sfloor  (sfloor),
    .sup     (sup),
    .sdown   (sdown),
    .fassign (fassign),
    .sassign (sassign),
    .pending (pending)
  );

  task automatic check(input string tag, input logic [NFLOORS-1:0] got, input logic [NFLOORS-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int car_cost(input int car, input bit up, input bit down, input int tgt);
    int c;
    c = (car > tgt) ? car - tgt : tgt - car;
    if (up && !down && tgt < car) c += 4;
    if (down && !up && tgt > car) c += 4;
    return c;
  endfunction

  task automatic model_edge();
    int nxt [NFLOORS];
    int first_wait;
    bit parked, fok, sok;
    int fc, sc;
    if (reset) begin
      foreach (call_owner[j]) call_owner[j] = 0;
      return;
    end
    first_wait = -1;
    for (int j = 0; j < NFLOORS; j++)
      if (first_wait < 0 && call_owner[j] == 1) first_wait = j;
    for (int j = 0; j < NFLOORS; j++) begin
      parked = (int'(ffloor) == j && !fup && !fdown) || (int'(sfloor) == j && !sup && !sdown);
      nxt[j] = call_owner[j];
      if (parked) nxt[j] = 0;
      else if (call_owner[j] == 0 && buttons[j]) nxt[j] = 1;
      else if (call_owner[j] == 1 && j == first_wait) begin
        fok = int'(ffloor) < NFLOORS;
        sok = int'(sfloor) < NFLOORS;
        fc  = car_cost(int'(ffloor), fup, fdown, j);
        sc  = car_cost(int'(sfloor), sup, sdown, j);
        if (fok && (!sok || fc <= sc)) nxt[j] = 2;
        else if (sok)                  nxt[j] = 3;
      end
    end
    call_owner = nxt;
  endtask

  task automatic step();
    logic [NFLOORS-1:0] ef, es, ep;
    @(posedge clk);
    model_edge();
    #1;
    for (int j = 0; j < NFLOORS; j++) begin
      ef[j] = (call_owner[j] == 2);
      es[j] = (call_owner[j] == 3);
      ep[j] = (call_owner[j] == 1);
    end
    check("fassign", fassign, ef);
    check("sassign", sassign, es);
    check("pending", pending, ep);
    check("exclusive", (fassign & sassign) | (fassign & pending) | (sassign & pending), '0);
  endtask

  task automatic set_cars(input int ff, input bit fu, input bit fd, input int sf, input bit su, input bit sd);
    ffloor = FLOOR_W'(ff); fup = fu; fdown = fd;
    sfloor = FLOOR_W'(sf); sup = su; sdown = sd;
  endtask

  task automatic do_reset();
    reset = 1'b1; buttons = '0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int r;
    reset = 1'b1; buttons = 5'b11111;
    set_cars(0, 1, 0, 4, 1, 0);
    step(); step();
    check("reset_pending", pending, 5'b00000);
    reset = 1'b0;
    step();
    check("release_pending", pending, 5'b11111);
    buttons = '0;

    do_reset();
    set_cars(0, 0, 0, 4, 1, 0);
    buttons = 5'b10000; step();
    check("top_pending", pending, 5'b10000);
    buttons = '0; step();
    check("top_to_s", sassign, 5'b10000);
    set_cars(0, 0, 0, 4, 0, 0); step();
    check("top_served", sassign, 5'b00000);

    do_reset();
    set_cars(2, 0, 0, 2, 0, 0);
    buttons = 5'b01000; step();
    buttons = '0; step();
    check("tie_to_f", fassign, 5'b01000);

    do_reset();
    set_cars(1, 0, 1, 4, 0, 0);
    buttons = 5'b01000; step();
    buttons = '0; step();
    check("penalty_to_s", sassign, 5'b01000);

    do_reset();
    set_cars(0, 1, 0, 4, 0, 1);
    buttons = 5'b10001; step();
    buttons = '0; step();
    check("first_low", fassign, 5'b00001);
    step();
    check("then_high", sassign, 5'b10000);
    do_reset();
    set_cars(0, 0, 0, 4, 1, 0);
    buttons = 5'b00001; step();
    check("press_at_parked", pending, 5'b00000);
    buttons = '0;

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset   = ($urandom_range(0, 249) == 0);
      buttons = ($urandom_range(0, 2) == 0) ? NFLOORS'($urandom) : '0;
      ffloor  = ($urandom_range(0, 9) == 0) ? FLOOR_W'($urandom_range(5, 7)) : FLOOR_W'($urandom_range(0, 4));
      sfloor  = ($urandom_range(0, 9) == 0) ? FLOOR_W'($urandom_range(5, 7)) : FLOOR_W'($urandom_range(0, 4));
      r = $urandom_range(0, 9);
      fup = (r == 5 || r == 6 || r == 9); fdown = (r == 7 || r == 8 || r == 9);
      r = $urandom_range(0, 9);
      sup = (r == 5 || r == 6 || r == 9); sdown = (r == 7 || r == 8 || r == 9);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
